// File: rtl/ne_syndrome_check.sv
// Serial syndrome checker for a quasi-cyclic code: re-encodes the message bits
// against generator rows fetched from an external ROM and compares with the received parity.
module ne_syndrome_check #(
   parameter int Z            = 511,
   parameter int MB           = 2,
   parameter int KB           = 14,
   parameter int ADDRESSWIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MB*Z-1:0]         rx_parity,
   input  logic                    msg_bit,
   input  logic                    msg_valid,
   output logic                    msg_ready,
   output logic [ADDRESSWIDTH-1:0] romaddress,
   output logic                    rden,
   input  logic [MB*Z-1:0]         f,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [MB*Z-1:0]         syndrome
);

   localparam int W  = MB * Z;
   localparam int BW = (Z > 1) ? $clog2(Z) : 1;
   localparam int KW = (KB > 1) ? $clog2(KB) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, CHECK} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   g_q, g_d;
   logic [W-1:0]   par_q, par_d;
   logic [W-1:0]   syn_q, syn_d;
   logic [W-1:0]   gRot;
   logic [BW-1:0]  bit_q, bit_d;
   logic [KW-1:0]  blk_q, blk_d;
   logic           err_q, err_d;
   logic           done_q, done_d;

   // Each circulant segment of the row register shifts one place toward its MSB, wrapping within the segment.
   always_comb begin
      gRot = '0;
      for (int k = 0; k < MB; k++) begin
         for (int i = 0; i < Z; i++) begin
            gRot[k*Z + i] = g_q[k*Z + ((i == 0) ? (Z - 1) : (i - 1))];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         g_q     <= '0;
         par_q   <= '0;
         syn_q   <= '0;
         bit_q   <= '0;
         blk_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         g_q     <= g_d;
         par_q   <= par_d;
         syn_q   <= syn_d;
         bit_q   <= bit_d;
         blk_q   <= blk_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      g_d     = g_q;
      par_d   = par_q;
      syn_d   = syn_q;
      bit_d   = bit_q;
      blk_d   = blk_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               par_d   = rx_parity;
               acc_d   = '0;
               bit_d   = '0;
               blk_d   = '0;
            end
         end
         LOAD: begin
            g_d     = f;
            state_d = RUN;
         end
         RUN: begin
            if (msg_valid) begin
               if (msg_bit) begin
                  acc_d = acc_q ^ g_q;
               end
               g_d = gRot;
               if (bit_q == BW'(Z - 1)) begin
                  bit_d = '0;
                  // The final block goes straight to CHECK so the block counter never passes KB-1.
                  if (blk_q == KW'(KB - 1)) begin
                     state_d = CHECK;
                  end else begin
                     blk_d   = blk_q + KW'(1);
                     state_d = LOAD;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         CHECK: begin
            syn_d   = acc_q ^ par_q;
            err_d   = |(acc_q ^ par_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are masked while reset is asserted so they read as idle in that very cycle.
   assign msg_ready  = !rst && (state_q == RUN);
   assign rden       = !rst && (state_q == LOAD);
   assign romaddress = rden ? ADDRESSWIDTH'(blk_q) : '0;
   assign busy       = !rst && (state_q != IDLE);
   assign done       = !rst && done_q;
   assign error      = !rst && err_q;
   assign syndrome   = rst ? '0 : syn_q;

endmodule

// File: tb/tb_ne_syndrome_check.sv
// Directed bench for ne_syndrome_check: a combinational generator ROM model and a
// reference encoder supply the expected syndromes.
module tb_ne_syndrome_check;

   localparam int Z  = 511;
   localparam int MB = 2;
   localparam int KB = 14;
   localparam int AW = 4;
   localparam int W  = MB * Z;
   localparam int FULL_LAT = KB * (Z + 1) + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  rx_parity;
   logic          msg_bit;
   logic          msg_valid;
   logic          msg_ready;
   logic [AW-1:0] romaddress;
   logic          rden;
   logic [W-1:0]  f;
   logic          busy;
   logic          done;
   logic          error;
   logic [W-1:0]  syndrome;

   logic [W-1:0]    romMem [KB];
   logic [KB*Z-1:0] msgBits;
   logic [W-1:0]    savedSyn;
   int              errors = 0;
   int              checks = 0;

   ne_syndrome_check #(.Z(Z), .MB(MB), .KB(KB), .ADDRESSWIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .rx_parity(rx_parity),
      .msg_bit(msg_bit), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .romaddress(romaddress), .rden(rden), .f(f), .busy(busy),
      .done(done), .error(error), .syndrome(syndrome)
   );

   always #5 clk = ~clk;

   assign f = (rden && (int'(romaddress) < KB)) ? romMem[romaddress] : '0;

   function automatic logic [W-1:0] romRow(input int r);
      logic [W-1:0] v;
      for (int j = 0; j < W; j++) v[j] = (((j * 37 + r * 101 + (j * j) % 29) % 7) < 3);
      return v;
   endfunction

   function automatic logic [W-1:0] rotSegBy(input logic [W-1:0] v, input int t);
      logic [W-1:0] r;
      for (int k = 0; k < MB; k++)
         for (int i = 0; i < Z; i++)
            r[k*Z + i] = v[k*Z + ((i - (t % Z) + Z) % Z)];
      return r;
   endfunction

   // Reference encoder: parity is the XOR of every ROM row rotated by the bit position of each set message bit.
   function automatic logic [W-1:0] encodeModel();
      logic [W-1:0] res;
      res = '0;
      for (int b = 0; b < KB; b++)
         for (int t = 0; t < Z; t++)
            if (msgBits[b*Z + t]) res ^= rotSegBy(romMem[b], t);
      return res;
   endfunction

   task automatic runCheck(input logic [W-1:0] par, input bit gapMode, input int pokeAt,
                           output logic [W-1:0] syn, output logic err, output int cycles,
                           output int rdenCnt, output bit addrOk, output int doneCnt,
                           output int gaps, output bit timedOut);
      int   idx;
      int   expAddr;
      logic accNow;
      idx = 0; expAddr = 0; rdenCnt = 0; addrOk = 1'b1; doneCnt = 0;
      gaps = 0; timedOut = 1'b0; cycles = 0; syn = '0; err = 1'b0;
      @(negedge clk);
      rx_parity = par; start = 1'b1; msg_valid = 1'b0; msg_bit = 1'b0;
      @(posedge clk);
      cycles = 1;
      @(negedge clk);
      start = 1'b0;
      rx_parity = ~par;
      for (int c = 0; c < 20000; c++) begin
         if (c > 0) @(negedge clk);
         if (done) begin
            syn = syndrome; err = error; doneCnt = 1;
            break;
         end
         if (rden) begin
            rdenCnt++;
            if (romaddress !== AW'(expAddr)) addrOk = 1'b0;
            expAddr++;
         end
         start     = (c == pokeAt);
         msg_valid = !(gapMode && ($urandom_range(0, 9) == 0));
         if (msg_ready && !msg_valid) gaps++;
         msg_bit   = (idx < KB*Z) ? msgBits[idx] : 1'b0;
         accNow    = msg_ready && msg_valid;
         @(posedge clk);
         cycles++;
         if (accNow) idx++;
      end
      if (doneCnt == 0) begin
         timedOut = 1'b1;
      end else begin
         @(negedge clk);
         start = 1'b0; msg_valid = 1'b0;
         if (done) doneCnt++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b1; msg_valid = 1'b1; msg_bit = 1'b1; rx_parity = '1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, msg_ready, rden, done, error} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, msg_ready, rden, done, error});
      end
      checks++;
      if (romaddress !== '0) begin
         errors++;
         $display("[TB] FAIL reset_addr: got %0d expected 0", romaddress);
      end
      checks++;
      if (syndrome !== '0) begin
         errors++;
         $display("[TB] FAIL reset_syn: ones=%0d expected 0", $countones(syndrome));
      end
      rst = 1'b0; start = 1'b0; msg_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_priority_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_zero_msg();
      logic [W-1:0] syn; logic err; int cyc, rc, dc, gp; bit aok, to;
      msgBits = '0;
      runCheck('0, 1'b0, -1, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (to) begin errors++; $display("[TB] FAIL zero_timeout: done not seen, expected by %0d", FULL_LAT); end
      checks++;
      if (cyc !== FULL_LAT) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected %0d", cyc, FULL_LAT); end
      checks++;
      if ({err, syn} !== '0) begin errors++; $display("[TB] FAIL zero_result: error=%b ones=%0d expected 0/0", err, $countones(syn)); end
      checks++;
      if (dc !== 1) begin errors++; $display("[TB] FAIL zero_done_width: got %0d expected 1", dc); end
      checks++;
      if (rc !== KB || !aok) begin errors++; $display("[TB] FAIL zero_rom_reads: got %0d order_ok=%b expected %0d/1", rc, aok, KB); end
   endtask

   task automatic test_single_bit();
      logic [W-1:0] syn, exp1; logic err; int cyc, rc, dc, gp; bit aok, to;
      msgBits = '0; msgBits[0] = 1'b1;
      runCheck(romMem[0], 1'b0, -1, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (to || err !== 1'b0 || syn !== '0) begin
         errors++;
         $display("[TB] FAIL bit0_match: timeout=%b error=%b ones=%0d expected 0/0/0", to, err, $countones(syn));
      end
      runCheck('0, 1'b0, -1, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (syn !== romMem[0]) begin
         errors++;
         $display("[TB] FAIL bit0_syn: low=%h expected low=%h", syn[63:0], romMem[0][63:0]);
      end
      checks++;
      if (err !== 1'b1) begin errors++; $display("[TB] FAIL bit0_error: got %b expected 1", err); end
      msgBits = '0; msgBits[1] = 1'b1;
      exp1 = rotSegBy(romMem[0], 1);
      runCheck('0, 1'b0, -1, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (syn !== exp1) begin
         errors++;
         $display("[TB] FAIL bit1_rot: low=%h hiseg=%h expected low=%h hiseg=%h",
                  syn[63:0], syn[Z+63:Z], exp1[63:0], exp1[Z+63:Z]);
      end
   endtask

   task automatic test_codeword();
      logic [W-1:0] syn, par, flip; logic err; int cyc, rc, dc, gp; bit aok, to;
      int ones [12] = '{3, 77, 510, 600, 1500, 2043, 2555, 3400, 4100, 5000, 6642, KB*Z-1};
      msgBits = '0;
      foreach (ones[i]) msgBits[ones[i]] = 1'b1;
      flip = '0; flip[600] = 1'b1;
      par = encodeModel() ^ flip;
      savedSyn = flip;
      runCheck(par, 1'b0, 100, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (to || syn !== flip) begin
         errors++;
         $display("[TB] FAIL flip600_syn: timeout=%b ones=%0d bit600=%b expected ones=1 bit600=1", to, $countones(syn), syn[600]);
      end
      checks++;
      if (err !== 1'b1) begin errors++; $display("[TB] FAIL flip600_error: got %b expected 1", err); end
      checks++;
      if (cyc !== FULL_LAT) begin errors++; $display("[TB] FAIL busy_start_ignored: latency %0d expected %0d", cyc, FULL_LAT); end
   endtask

   task automatic test_gaps();
      logic [W-1:0] syn; logic err; int cyc, rc, dc, gp; bit aok, to;
      logic [W-1:0] par;
      par = encodeModel() ^ savedSyn;
      runCheck(par, 1'b1, -1, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (to || syn !== savedSyn) begin
         errors++;
         $display("[TB] FAIL gaps_syn: timeout=%b ones=%0d expected ones=1", to, $countones(syn));
      end
      checks++;
      if (gp == 0) begin errors++; $display("[TB] FAIL gaps_present: got %0d expected >0", gp); end
      checks++;
      if (cyc !== FULL_LAT + gp) begin errors++; $display("[TB] FAIL gaps_latency: got %0d expected %0d", cyc, FULL_LAT + gp); end
      checks++;
      if (rc !== KB) begin errors++; $display("[TB] FAIL gaps_rden_count: got %0d expected %0d", rc, KB); end
      checks++;
      if (!aok) begin errors++; $display("[TB] FAIL gaps_rom_order: got %b expected 1", aok); end
   endtask

   task automatic test_abort();
      logic [W-1:0] syn; logic err; int cyc, rc, dc, gp; bit aok, to;
      int seenDone, after;
      bit reached;
      msgBits = '1;
      seenDone = 0; after = -1; reached = 1'b0;
      @(negedge clk);
      rx_parity = '0; start = 1'b1; msg_valid = 1'b1; msg_bit = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         if (done) seenDone++;
         if (rden && romaddress == AW'(7)) after = 0;
         if (after >= 0) after++;
         if (after == 30) begin reached = 1'b1; break; end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (!reached || busy !== 1'b1 || msg_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_in_block7: reached=%b busy=%b ready=%b expected 1/1/1", reached, busy, msg_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, msg_ready, done} !== 3'b0 || syndrome !== '0) begin
         errors++;
         $display("[TB] FAIL abort_reset_outputs: ctrl=%b ones=%0d expected 000/0", {busy, msg_ready, done}, $countones(syndrome));
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; msg_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (done || busy) seenDone++;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (seenDone !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", seenDone); end
      msgBits = '0;
      runCheck('0, 1'b0, -1, syn, err, cyc, rc, aok, dc, gp, to);
      checks++;
      if (to || err !== 1'b0 || syn !== '0) begin
         errors++;
         $display("[TB] FAIL abort_fresh_result: timeout=%b error=%b ones=%0d expected 0/0/0", to, err, $countones(syn));
      end
      checks++;
      if (dc !== 1 || cyc !== FULL_LAT) begin
         errors++;
         $display("[TB] FAIL abort_fresh_timing: done_cycles=%0d latency=%0d expected 1/%0d", dc, cyc, FULL_LAT);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rx_parity = '0; msg_bit = 1'b0; msg_valid = 1'b0;
      msgBits = '0; savedSyn = '0;
      for (int r = 0; r < KB; r++) romMem[r] = romRow(r);
      test_reset();
      test_zero_msg();
      test_single_bit();
      test_codeword();
      test_gaps();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ne_syndrome_check.md
NE_SYNDROME_CHECK -- requirements
Module: ne_syndrome_check

Interface
REQ-001 SHALL have parameter Z, default 511, circulant size in bits.
REQ-002 SHALL have parameter MB, default 2, number of parity block columns.
REQ-003 SHALL have parameter KB, default 14, number of message block rows, equal to the generator ROM depth used.
REQ-004 SHALL have parameter ADDRESSWIDTH, default 4, generator ROM address width.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, one-cycle request to check one codeword.
REQ-009 SHALL have port rx_parity, input, MB*Z, received parity bits, sampled on accepted start.
REQ-010 SHALL have port msg_bit, input, 1, received message bit, serial, block 0 bit 0 first.
REQ-011 SHALL have port msg_valid, input, 1, msg_bit qualifier.
REQ-012 SHALL have port msg_ready, output, 1, block accepts msg_bit this cycle.
REQ-013 SHALL have port romaddress, output, ADDRESSWIDTH, generator ROM row select.
REQ-014 SHALL have port rden, output, 1, generator ROM read enable.
REQ-015 SHALL have port f, input, MB*Z, generator ROM data, combinational from romaddress/rden.
REQ-016 SHALL have port busy, output, 1, check in progress.
REQ-017 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-018 SHALL have port error, output, 1, OR-reduction of syndrome, held until next done.
REQ-019 SHALL have port syndrome, output, MB*Z, recomputed parity XOR rx_parity, held until next done.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, RUN, CHECK.
REQ-021 IDLE: start=1 -> LOAD; SHALL latch rx_parity, clear accumulator acc, block counter blk=0, bit counter bit=0.
REQ-022 start while not IDLE SHALL be ignored.
REQ-023 LOAD: rden=1, romaddress=blk; one cycle; SHALL capture f into row register g at its end; -> RUN.
REQ-024 Outside LOAD: rden=0, romaddress=0.
REQ-025 RUN: msg_ready=1; a bit is accepted when msg_valid=1 and msg_ready=1.
REQ-026 On accepted bit: if msg_bit=1, acc <= acc XOR g; always g rotates each Z-bit segment k (bits k*Z .. k*Z+Z-1) by one toward MSB: new bit i = old bit (i-1) mod Z within segment.
REQ-027 Accepted bit with bit=Z-1: bit<=0, blk<=blk+1; if blk=KB-1 -> CHECK, else -> LOAD.
REQ-028 msg_valid=0 in RUN SHALL leave acc, g, counters unchanged (gaps allowed, arbitrary length).
REQ-029 msg_ready SHALL be 0 in IDLE, LOAD, CHECK; msg_bit ignored there.
REQ-030 CHECK: one cycle; at its end syndrome <= acc XOR latched rx_parity, error <= |(acc XOR rx_parity), done <= 1; -> IDLE.
REQ-031 done SHALL be high exactly one cycle (cycle after CHECK); start accepted in that cycle.
REQ-032 busy SHALL be 1 in LOAD, RUN, CHECK; 0 in IDLE.
REQ-033 Latency with msg_valid held 1: start edge to done high = KB*(Z+1)+2 cycles (7170 at defaults).
REQ-034 Counter widths SHALL hold Z-1 and KB-1 without overflow; no wrap beyond KB blocks.

Reset
REQ-035 rst=1 SHALL force IDLE, acc=0, g=0, blk=0, bit=0, latched parity=0.
REQ-036 rst=1 SHALL force outputs msg_ready=0, rden=0, romaddress=0, busy=0, done=0, error=0, syndrome=0.
REQ-037 rst mid-operation SHALL abort with no done; next start SHALL run a full fresh check.
REQ-038 rst SHALL take priority over start and msg_valid in the same cycle.

Verification
REQ-039 All 7154 message bits 0, rx_parity=0 -> done after 7170 cycles, error=0, syndrome=0.
REQ-040 Only block 0 bit 0 =1, rx_parity=ROM[0] -> error=0; rx_parity=0 -> syndrome=ROM[0].
REQ-041 Only block 0 bit 1 =1, rx_parity=0 -> syndrome = ROM[0] with each segment rotated one toward MSB.
REQ-042 Valid codeword, one rx_parity bit flipped (bit 600) -> error=1, syndrome has only bit 600 set.
REQ-043 Same codeword with random msg_valid gaps -> identical syndrome, done delayed by gap count; rden high exactly 14 cycles, romaddress 0..13 in order.
REQ-044 rst asserted during block 7 RUN, then new start with zero message -> single done, error=0, no stale acc.
